// File: rtl/dcache_controller_if.sv
// dcache_controller_if: CPU-side and memory-side buses of the data cache.
interface dcache_controller_if;
  logic READ, WRITE, BUSYWAIT, MISS;
  logic [31:0] ADDRESS, WRITEDATA, READDATA;
  logic MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [27:0] MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA, MEM_READDATA;
  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input READDATA, BUSYWAIT, MISS, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
  modport slave (
    input READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MISS, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate data cache with miss pulse.
module dcache_controller #(
  parameter int SETS = 8,
  parameter int TAG_W = 32 - 4 - $clog2(SETS)
) (
  input logic CLOCK,
  input logic RESET,
  dcache_controller_if.slave bus
);
  localparam int IW = $clog2(SETS);
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;
  state_t state, next;
  logic [SETS-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [SETS];
  logic [127:0] data [SETS];
  logic [127:0] fill;
  logic [IW-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0] off;
  logic req, hit, miss, wr_hit, unused_bits;
  assign idx = bus.ADDRESS[4 +: IW];
  assign req_tag = bus.ADDRESS[31 -: TAG_W];
  assign off = bus.ADDRESS[3:2];
  assign unused_bits = ^bus.ADDRESS[1:0];
  assign req = bus.READ | bus.WRITE;
  assign hit = valid[idx] && tags[idx] == req_tag && req;
  assign miss = state == IDLE && req && !hit;
  assign wr_hit = state == IDLE && hit && bus.WRITE;
  always_comb begin
    next = state;
    bus.BUSYWAIT = 1'b1;
    bus.MEM_READ = 1'b0;
    bus.MEM_WRITE = 1'b0;
    bus.MEM_ADDRESS = {req_tag, idx};
    bus.MEM_WRITEDATA = data[idx];
    bus.READDATA = data[idx][{off, 5'd0} +: 32];
    case (state)
      IDLE: begin
        bus.BUSYWAIT = miss;
        next = !miss ? IDLE : (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        bus.MEM_WRITE = 1'b1;
        bus.MEM_ADDRESS = {tags[idx], idx};
        next = bus.MEM_BUSYWAIT ? WRITEBACK : ALLOCATE;
      end
      ALLOCATE: begin
        bus.MEM_READ = 1'b1;
        next = bus.MEM_BUSYWAIT ? ALLOCATE : UPDATE;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      bus.MISS <= 1'b0;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= next;
      bus.MISS <= miss;
      if (state == UPDATE) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty[idx] <= 1'b1;
      end
    end
  end
  // Async reset forces IDLE and clears valid, so none of these writes can fire under reset.
  always_ff @(posedge CLOCK) begin
    if (state == ALLOCATE && !bus.MEM_BUSYWAIT) fill <= bus.MEM_READDATA;
    if (state == UPDATE) begin
      data[idx] <= fill;
      tags[idx] <= req_tag;
    end else if (wr_hit) begin
      data[idx][{off, 5'd0} +: 32] <= bus.WRITEDATA;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed checks of hits, clean/dirty misses, write-allocate and reset abort.
module tb_dcache_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  dcache_controller_if bus();
  dcache_controller dut (.CLOCK(clk), .RESET(rst), .bus(bus));
  int checks = 0, errors = 0, miss_cnt, busy, misses;
  logic [2:0] mcnt;
  logic mr_seen, mw_seen;
  logic [27:0] mr_addr, mw_addr;
  logic [127:0] mw_data;
  logic [31:0] rdata;
  function automatic logic [127:0] block(input logic [27:0] b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = {b, w[1:0], 2'b00} ^ 32'hA500_0000;
    return r;
  endfunction
  assign bus.MEM_BUSYWAIT = (bus.MEM_READ | bus.MEM_WRITE) && mcnt != 3'd5;
  assign bus.MEM_READDATA = block(bus.MEM_ADDRESS);
  always @(posedge clk or posedge rst) mcnt <= rst ? 3'd0 : bus.MEM_BUSYWAIT ? mcnt + 3'd1 : 3'd0;
  always @(posedge clk or posedge rst) miss_cnt <= rst ? 0 : miss_cnt + int'(bus.MISS);
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    int n;
    bus.READ = rd;
    bus.WRITE = wr;
    bus.ADDRESS = a;
    bus.WRITEDATA = wd;
    busy = 0;
    misses = 0;
    mr_seen = 1'b0;
    mw_seen = 1'b0;
    mr_addr = '0;
    mw_addr = '0;
    mw_data = '0;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.MISS) misses++;
      if (bus.MEM_READ) begin
        mr_seen = 1'b1;
        mr_addr = bus.MEM_ADDRESS;
      end
      if (bus.MEM_WRITE) begin
        mw_seen = 1'b1;
        mw_addr = bus.MEM_ADDRESS;
        mw_data = bus.MEM_WRITEDATA;
      end
      if (!bus.BUSYWAIT) begin
        rdata = bus.READDATA;
        break;
      end
      busy++;
      if (++n > 200) begin
        checks++;
        errors++;
        $error("FAIL timeout observed BUSYWAIT stuck expected release");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
  endtask
  initial begin
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
    bus.ADDRESS = '0;
    bus.WRITEDATA = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_miss", bus.MISS, 0);
    chk("rst_mem_read", bus.MEM_READ, 0);
    chk("rst_mem_write", bus.MEM_WRITE, 0);
    chk("rst_busy", bus.BUSYWAIT, 0);
    @(posedge clk);
    #1;
    access(1, 0, 32'h40, 0);
    chk("m1_busy", busy, 8);
    chk("m1_miss", misses, 1);
    chk("m1_mr", mr_seen, 1);
    chk("m1_mr_addr", mr_addr, 28'h4);
    chk("m1_mw", mw_seen, 0);
    chk("m1_data", rdata, 32'hA500_0040);
    access(1, 0, 32'h44, 0);
    chk("h1_busy", busy, 0);
    chk("h1_miss", misses, 0);
    chk("h1_data", rdata, 32'hA500_0044);
    access(0, 1, 32'h48, 32'hDEAD_BEEF);
    chk("wh_busy", busy, 0);
    access(1, 0, 32'h48, 0);
    chk("wh_rd_busy", busy, 0);
    chk("wh_rd_data", rdata, 32'hDEAD_BEEF);
    access(1, 0, 32'hC0, 0);
    chk("dm_busy", busy, 14);
    chk("dm_miss", misses, 1);
    chk("dm_mw_addr", mw_addr, 28'h4);
    chk("dm_mw_data", mw_data, {32'hA500_004C, 32'hDEAD_BEEF, 32'hA500_0044, 32'hA500_0040});
    chk("dm_mr_addr", mr_addr, 28'hC);
    chk("dm_data", rdata, 32'hA500_00C0);
    chk("miss_count", miss_cnt, 2);
    access(0, 1, 32'h100, 32'h1234_5678);
    chk("wm_busy", busy, 8);
    chk("wm_miss", misses, 1);
    chk("wm_mw", mw_seen, 0);
    chk("wm_mr_addr", mr_addr, 28'h10);
    access(1, 0, 32'h100, 0);
    chk("wm_rd0", rdata, 32'h1234_5678);
    access(1, 0, 32'h104, 0);
    chk("wm_rd1", rdata, 32'hA500_0104);
    access(1, 0, 32'h300, 0);
    chk("wm_dirty_busy", busy, 14);
    chk("wm_dirty_mw_addr", mw_addr, 28'h10);
    chk("wm_dirty_mw_data", mw_data, {32'hA500_010C, 32'hA500_0108, 32'hA500_0104, 32'h1234_5678});
    chk("wm_dirty_mr_addr", mr_addr, 28'h30);
    chk("wm_dirty_data", rdata, 32'hA500_0300);
    bus.READ = 1'b1;
    bus.ADDRESS = 32'h40;
    repeat (3) @(posedge clk);
    #3;
    chk("ra_mem_read_pre", bus.MEM_READ, 1);
    rst = 1'b1;
    #1;
    chk("ra_mem_read", bus.MEM_READ, 0);
    chk("ra_mem_write", bus.MEM_WRITE, 0);
    chk("ra_miss", bus.MISS, 0);
    bus.READ = 1'b0;
    #1;
    chk("ra_busy_idle", bus.BUSYWAIT, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    access(1, 0, 32'hC0, 0);
    chk("ra_rd_busy", busy, 8);
    chk("ra_rd_miss", misses, 1);
    chk("ra_rd_data", rdata, 32'hA500_00C0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
